// File: rtl/rom_port_arbiter_if.sv
// Bus bundle between the fetch/load requesters, the arbiter and the ROM.
// Arbiter uses the slave modport; the requester/ROM side uses master.
interface rom_port_arbiter_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    // fetch port
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              i_err;
    // load port
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;
    // ROM side
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    modport slave (
        input  i_req, i_addr, d_req, d_addr, rom_data,
        output i_gnt, i_rvalid, i_rdata, i_err,
        output d_gnt, d_rvalid, d_rdata, d_err, rom_addr
    );

    modport master (
        output i_req, i_addr, d_req, d_addr, rom_data,
        input  i_gnt, i_rvalid, i_rdata, i_err,
        input  d_gnt, d_rvalid, d_rdata, d_err, rom_addr
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// Two-port arbiter in front of the single-port instruction ROM.
// Load port wins by default; fetch is forced through after MAX_STALL
// consecutive denied cycles. Responses come exactly one cycle after the
// grant, with out-of-range addresses answered by err=1 and zero data.
module rom_port_arbiter #(
    parameter int ADDR_W    = 30,
    parameter int DATA_W    = 32,
    parameter int ROM_DEPTH = 66,
    parameter int MAX_STALL = 4
) (
    input  logic                clk,
    input  logic                rst,      // async, active low
    rom_port_arbiter_if.slave   bus
);
    localparam int STALL_W = $clog2(MAX_STALL + 1);

    typedef enum logic [1:0] {SEL_NONE, SEL_I, SEL_D} sel_e;

    logic [STALL_W-1:0] stall_q, stall_d;
    logic [ADDR_W-1:0]  addr_hold_q, addr_hold_d;
    sel_e               resp_sel_q, resp_sel_d;
    logic               resp_oob_q, resp_oob_d;

    logic               force_i;
    logic               pick_i, pick_d;
    logic               gnt_i, gnt_d, any_gnt;
    logic [ADDR_W-1:0]  gnt_addr;

    // Arbitration: depends only on requests and the stall counter, never on rom_data.
    always_comb begin
        force_i  = bus.i_req && (stall_q == STALL_W'(MAX_STALL));
        pick_i   = force_i || (!bus.d_req && bus.i_req);
        pick_d   = !force_i && bus.d_req;
        // Grants are suppressed while reset is held; the address mux is not,
        // so rom_addr still follows a pending request.
        gnt_i    = pick_i && rst;
        gnt_d    = pick_d && rst;
        any_gnt  = gnt_i || gnt_d;
        gnt_addr = pick_d ? bus.d_addr : bus.i_addr;
    end

    assign bus.i_gnt    = gnt_i;
    assign bus.d_gnt    = gnt_d;
    // Hold the last granted address when idle so the ROM input does not toggle.
    assign bus.rom_addr = (pick_i || pick_d) ? gnt_addr : addr_hold_q;

    // Next-state for the starvation counter, address hold and response tags.
    always_comb begin
        stall_d = stall_q;
        if (!bus.i_req || gnt_i)
            stall_d = '0;
        else if (stall_q != STALL_W'(MAX_STALL))
            stall_d = stall_q + 1'b1;

        addr_hold_d = any_gnt ? gnt_addr : addr_hold_q;

        resp_sel_d = SEL_NONE;
        if (gnt_d)
            resp_sel_d = SEL_D;
        else if (gnt_i)
            resp_sel_d = SEL_I;

        resp_oob_d = any_gnt && (gnt_addr >= ADDR_W'(ROM_DEPTH));
    end

    // State registers; async reset drops any response in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q     <= '0;
            addr_hold_q <= '0;
            resp_sel_q  <= SEL_NONE;
            resp_oob_q  <= 1'b0;
        end else begin
            stall_q     <= stall_d;
            addr_hold_q <= addr_hold_d;
            resp_sel_q  <= resp_sel_d;
            resp_oob_q  <= resp_oob_d;
        end
    end

    // Response steering: only the owner sees valid/data/err; oob data is forced to 0.
    always_comb begin
        bus.i_rvalid = (resp_sel_q == SEL_I);
        bus.i_err    = (resp_sel_q == SEL_I) && resp_oob_q;
        bus.i_rdata  = ((resp_sel_q == SEL_I) && !resp_oob_q) ? bus.rom_data : '0;
        bus.d_rvalid = (resp_sel_q == SEL_D);
        bus.d_err    = (resp_sel_q == SEL_D) && resp_oob_q;
        bus.d_rdata  = ((resp_sel_q == SEL_D) && !resp_oob_q) ? bus.rom_data : '0;
    end
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter with a behavioural ROM and a
// scoreboard of expected responses pushed at grant time.
module tb_rom_port_arbiter;
    localparam int ADDR_W    = 30;
    localparam int DATA_W    = 32;
    localparam int ROM_DEPTH = 66;
    localparam int MAX_STALL = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rom_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rom_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .ROM_DEPTH(ROM_DEPTH), .MAX_STALL(MAX_STALL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ROM model: registered address, combinational read, garbage beyond depth
    logic [DATA_W-1:0] mem [0:ROM_DEPTH-1];
    logic [ADDR_W-1:0] rom_addr_q = '0;
    always @(posedge clk) rom_addr_q <= bus.rom_addr;
    assign bus.rom_data = (rom_addr_q < ADDR_W'(ROM_DEPTH)) ? mem[rom_addr_q[6:0]] : 32'hDEAD_BEEF;

    logic [67:0] resp_w;
    assign resp_w = {bus.i_rvalid, bus.i_rdata, bus.i_err, bus.d_rvalid, bus.d_rdata, bus.d_err};

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int          m_stall = 0;
    logic [29:0] m_hold  = '0;
    logic        eg_i, eg_d;
    logic [29:0] e_addr;
    int          e_stall;
    logic [67:0] sb_q [$];
    logic [67:0] exp_r;

    // Drive one cycle of requests (at negedge) and push the predicted response.
    task automatic step(input logic ir, input logic [29:0] ia, input logic dr, input logic [29:0] da);
        logic        force_i, oob;
        logic [29:0] ga;
        logic [31:0] gd;
        bus.i_req  = ir;
        bus.i_addr = ia;
        bus.d_req  = dr;
        bus.d_addr = da;
        force_i = ir && (m_stall == MAX_STALL);
        eg_i    = force_i || (!dr && ir);
        eg_d    = !force_i && dr;
        ga      = eg_d ? da : ia;
        e_addr  = (eg_i || eg_d) ? ga : m_hold;
        e_stall = m_stall;
        oob     = ga >= 30'(ROM_DEPTH);
        gd      = oob ? 32'h0 : mem[ga[6:0]];
        if (eg_d)      sb_q.push_back({1'b0, 32'h0, 1'b0, 1'b1, gd, oob});
        else if (eg_i) sb_q.push_back({1'b1, gd, oob, 1'b0, 32'h0, 1'b0});
        else           sb_q.push_back(68'h0);
        if (eg_i || eg_d) m_hold = ga;
        if (!ir || eg_i) m_stall = 0;
        else if (m_stall < MAX_STALL) m_stall = m_stall + 1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (resp_w !== 68'h0 || bus.i_gnt !== 1'b0 || bus.d_gnt !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: got resp=%h gnt=%b%b want all 0", resp_w, bus.i_gnt, bus.d_gnt);
        end
        n_checks++;
        if (bus.rom_addr !== 30'h0) begin
            n_fail++; $display("FAIL reset_rom_addr: got %h want 0", bus.rom_addr);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single();
        bit          ir [3] = '{0, 1, 0};
        logic [29:0] ia [3] = '{30'h0, 30'h00, 30'h0};
        for (int c = 0; c < 3; c++) begin
            step(ir[c], ia[c], 1'b0, 30'h0); #1;
            n_checks++;
            if ({bus.i_gnt, bus.d_gnt} !== {eg_i, eg_d}) begin
                n_fail++; $display("FAIL single_gnt c%0d: got %b%b want %b%b", c, bus.i_gnt, bus.d_gnt, eg_i, eg_d);
            end
            @(posedge clk); #1;
            exp_r = sb_q.pop_front();
            n_checks++;
            if (resp_w !== exp_r) begin
                n_fail++; $display("FAIL single_resp c%0d: got %h want %h", c, resp_w, exp_r);
            end
            if (c == 1) begin
                n_checks++;
                if (bus.i_rdata !== 32'h3707_0010 || bus.i_rvalid !== 1'b1 || bus.d_rvalid !== 1'b0) begin
                    n_fail++; $display("FAIL single_word0: got %h want 37070010", bus.i_rdata);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_collision();
        bit          ir [5] = '{1, 1, 0, 1, 0};
        logic [29:0] ia [5] = '{30'h01, 30'h01, 30'h0, 30'h05, 30'h0};
        bit          dr [5] = '{1, 0, 0, 1, 0};
        logic [29:0] da [5] = '{30'h3E, 30'h0, 30'h0, 30'h05, 30'h0};
        for (int c = 0; c < 5; c++) begin
            step(ir[c], ia[c], dr[c], da[c]); #1;
            n_checks++;
            if ({bus.i_gnt, bus.d_gnt} !== {eg_i, eg_d}) begin
                n_fail++; $display("FAIL coll_gnt c%0d: got %b%b want %b%b", c, bus.i_gnt, bus.d_gnt, eg_i, eg_d);
            end
            n_checks++;
            if (bus.rom_addr !== e_addr) begin
                n_fail++; $display("FAIL coll_rom_addr c%0d: got %h want %h", c, bus.rom_addr, e_addr);
            end
            @(posedge clk); #1;
            exp_r = sb_q.pop_front();
            n_checks++;
            if (resp_w !== exp_r) begin
                n_fail++; $display("FAIL coll_resp c%0d: got %h want %h", c, resp_w, exp_r);
            end
            if (c == 0) begin
                n_checks++;
                if (bus.d_rdata !== 32'h4845_4C4C) begin
                    n_fail++; $display("FAIL coll_d_word: got %h want 48454C4C", bus.d_rdata);
                end
            end
            if (c == 1) begin
                n_checks++;
                if (bus.i_rdata !== 32'h1307_0760) begin
                    n_fail++; $display("FAIL coll_i_word: got %h want 13070760", bus.i_rdata);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_starvation();
        for (int c = 0; c < 12; c++) begin
            if (c < 11) step(1'b1, 30'h03, 1'b1, 30'h10);
            else        step(1'b0, 30'h0, 1'b0, 30'h0);
            #1;
            n_checks++;
            if ({bus.i_gnt, bus.d_gnt} !== {eg_i, eg_d}) begin
                n_fail++; $display("FAIL starve_gnt c%0d: got %b%b want %b%b", c, bus.i_gnt, bus.d_gnt, eg_i, eg_d);
            end
            n_checks++;
            if (int'(dut.stall_q) !== e_stall) begin
                n_fail++; $display("FAIL starve_cnt c%0d: got %0d want %0d", c, dut.stall_q, e_stall);
            end
            if (c == 4 || c == 9) begin
                n_checks++;
                if (bus.i_gnt !== 1'b1 || int'(dut.stall_q) !== MAX_STALL) begin
                    n_fail++; $display("FAIL starve_force c%0d: got i_gnt=%b cnt=%0d want 1/%0d", c, bus.i_gnt, dut.stall_q, MAX_STALL);
                end
            end
            @(posedge clk); #1;
            exp_r = sb_q.pop_front();
            n_checks++;
            if (resp_w !== exp_r) begin
                n_fail++; $display("FAIL starve_resp c%0d: got %h want %h", c, resp_w, exp_r);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_out_of_range();
        bit          ir [5] = '{0, 0, 1, 1, 0};
        logic [29:0] ia [5] = '{30'h0, 30'h0, 30'h3FFF_FFFF, 30'h42, 30'h0};
        bit          dr [5] = '{1, 1, 0, 0, 0};
        logic [29:0] da [5] = '{30'h42, 30'h41, 30'h0, 30'h0, 30'h0};
        for (int c = 0; c < 5; c++) begin
            step(ir[c], ia[c], dr[c], da[c]); #1;
            n_checks++;
            if ({bus.i_gnt, bus.d_gnt} !== {eg_i, eg_d} || bus.rom_addr !== e_addr) begin
                n_fail++; $display("FAIL oob_gnt c%0d: got %b%b addr %h want %b%b addr %h", c, bus.i_gnt, bus.d_gnt, bus.rom_addr, eg_i, eg_d, e_addr);
            end
            @(posedge clk); #1;
            exp_r = sb_q.pop_front();
            n_checks++;
            if (resp_w !== exp_r) begin
                n_fail++; $display("FAIL oob_resp c%0d: got %h want %h", c, resp_w, exp_r);
            end
            if (c == 0) begin
                n_checks++;
                if (bus.d_rvalid !== 1'b1 || bus.d_err !== 1'b1 || bus.d_rdata !== 32'h0) begin
                    n_fail++; $display("FAIL oob_d_err: got v=%b e=%b d=%h want 1/1/0", bus.d_rvalid, bus.d_err, bus.d_rdata);
                end
            end
            if (c == 1) begin
                n_checks++;
                if (bus.d_err !== 1'b0 || bus.d_rdata !== 32'h2100_0000) begin
                    n_fail++; $display("FAIL oob_last_word: got e=%b d=%h want 0/21000000", bus.d_err, bus.d_rdata);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        bit          ir [5] = '{1, 0, 1, 0, 0};
        logic [29:0] ia [5] = '{30'h37, 30'h0, 30'h05, 30'h0, 30'h0};
        bit          dr [5] = '{0, 1, 0, 0, 0};
        logic [29:0] da [5] = '{30'h0, 30'h40, 30'h0, 30'h0, 30'h0};
        logic [31:0] want [3] = '{32'h6780_0000, 32'h524C_4421, 32'h0100_0000};
        for (int c = 0; c < 5; c++) begin
            step(ir[c], ia[c], dr[c], da[c]); #1;
            n_checks++;
            if ({bus.i_gnt, bus.d_gnt} !== {eg_i, eg_d} || bus.rom_addr !== e_addr) begin
                n_fail++; $display("FAIL b2b_gnt c%0d: got %b%b addr %h want %b%b addr %h", c, bus.i_gnt, bus.d_gnt, bus.rom_addr, eg_i, eg_d, e_addr);
            end
            if (c == 3) begin
                n_checks++;
                if (bus.rom_addr !== 30'h05) begin
                    n_fail++; $display("FAIL b2b_hold: got %h want 05", bus.rom_addr);
                end
            end
            @(posedge clk); #1;
            exp_r = sb_q.pop_front();
            n_checks++;
            if (resp_w !== exp_r) begin
                n_fail++; $display("FAIL b2b_resp c%0d: got %h want %h", c, resp_w, exp_r);
            end
            if (c < 3) begin
                n_checks++;
                if ((bus.i_rdata | bus.d_rdata) !== want[c]) begin
                    n_fail++; $display("FAIL b2b_word c%0d: got %h want %h", c, bus.i_rdata | bus.d_rdata, want[c]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_in_flight();
        step(1'b0, 30'h0, 1'b1, 30'h3F); #1;
        n_checks++;
        if (bus.d_gnt !== 1'b1) begin
            n_fail++; $display("FAIL rif_gnt: got %b want 1", bus.d_gnt);
        end
        #2;
        rst = 1'b0;
        bus.i_req = 1'b0; bus.d_req = 1'b0; bus.i_addr = '0; bus.d_addr = '0;
        sb_q.delete();
        m_stall = 0;
        m_hold  = '0;
        #1;
        n_checks++;
        if (resp_w !== 68'h0 || bus.rom_addr !== 30'h0 || bus.d_gnt !== 1'b0) begin
            n_fail++; $display("FAIL rif_async: got resp=%h addr=%h gnt=%b want 0", resp_w, bus.rom_addr, bus.d_gnt);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.d_rvalid !== 1'b0 || resp_w !== 68'h0) begin
            n_fail++; $display("FAIL rif_dropped: got d_rvalid=%b resp=%h want 0", bus.d_rvalid, resp_w);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step(c == 0, 30'h02, 1'b0, 30'h0); #1;
            n_checks++;
            if ({bus.i_gnt, bus.d_gnt} !== {eg_i, eg_d}) begin
                n_fail++; $display("FAIL rif_regnt c%0d: got %b%b want %b%b", c, bus.i_gnt, bus.d_gnt, eg_i, eg_d);
            end
            @(posedge clk); #1;
            exp_r = sb_q.pop_front();
            n_checks++;
            if (resp_w !== exp_r || bus.d_rvalid !== 1'b0) begin
                n_fail++; $display("FAIL rif_resp c%0d: got %h want %h", c, resp_w, exp_r);
            end
            if (c == 0) begin
                n_checks++;
                if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'hEF00_4000) begin
                    n_fail++; $display("FAIL rif_word: got v=%b d=%h want 1/EF004000", bus.i_rvalid, bus.i_rdata);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < ROM_DEPTH; i++)
            mem[i] = 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
        mem[8'h00] = 32'h3707_0010;
        mem[8'h01] = 32'h1307_0760;
        mem[8'h02] = 32'hEF00_4000;
        mem[8'h05] = 32'h0100_0000;
        mem[8'h37] = 32'h6780_0000;
        mem[8'h3E] = 32'h4845_4C4C;
        mem[8'h3F] = 32'h4F2C_2057;
        mem[8'h40] = 32'h524C_4421;
        mem[8'h41] = 32'h2100_0000;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_addr = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_collision();
        test_starvation();
        test_out_of_range();
        test_back_to_back();
        test_reset_in_flight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single-port instruction ROM (registered word address, combinational read, one-cycle read latency) between two requesters: the instruction-fetch port (I) and the data-load port (D).
- D loads read constant/string data stored in the ROM image.
- Data-port priority by default, plus a starvation guard for fetch.
- Out-of-range addresses get an error response.
- Sits between the core's fetch/load units and the ROM instance.

Parameters:
- ADDR_W, 30, word-address width (matches ROM address port).
- DATA_W, 32, ROM word width.
- ROM_DEPTH, 66, number of populated ROM words; valid addresses are 0..ROM_DEPTH-1.
- MAX_STALL, 4, consecutive denied cycles after which I is forced to win.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request.
- i_addr  in  ADDR_W  fetch word address.
- i_gnt  out  1  fetch request accepted this cycle (combinational).
- i_rvalid  out  1  fetch response valid.
- i_rdata  out  DATA_W  fetch response data.
- i_err  out  1  fetch response is out-of-range.
- d_req  in  1  load request.
- d_addr  in  ADDR_W  load word address.
- d_gnt  out  1  load accepted this cycle.
- d_rvalid  out  1  load response valid.
- d_rdata  out  DATA_W  load response data.
- d_err  out  1  load response is out-of-range.
- rom_addr  out  ADDR_W  address to ROM; the ROM registers it every clk.
- rom_data  in  DATA_W  ROM read word for the address registered last cycle.

Behaviour:
- Grant logic (combinational, same cycle as req):
  - At most one grant per cycle; a granted request is consumed that cycle.
  - force_i = i_req && (stall_cnt == MAX_STALL).
  - If force_i: i_gnt=1, d_gnt=0.
  - Else if d_req: d_gnt=1.
  - Else if i_req: i_gnt=1.
  - Else: no grant.
- rom_addr:
  - Equals the granted port's address.
  - With no grant, holds the last granted address (register addr_hold, reset 0) to avoid ROM toggling.
- stall_cnt (width clog2(MAX_STALL+1), reset 0):
  - Increments, saturating at MAX_STALL, each cycle i_req && !i_gnt.
  - Clears on i_gnt or when !i_req.
- Response pipeline: registers resp_sel (NONE/I/D, reset NONE) and resp_oob (reset 0), captured at each clk from the current grant and from (granted addr >= ROM_DEPTH).
  - Cycle after a grant: owner's rvalid=1.
  - rdata = rom_data if !resp_oob, else 0; err = resp_oob.
  - The non-owner's rvalid, rdata and err are all 0.
  - With resp_sel=NONE, all outputs are 0.
- Latency and throughput:
  - Exactly 1 cycle, request-to-response.
  - Back-to-back grants give one response per cycle, any port mix, in grant order.
  - No response backpressure: requesters must accept rvalid when it comes.
- Out-of-range:
  - The request is still granted, the ROM is still addressed, and the response carries err=1, data 0.
  - Does not affect stall_cnt rules.
- Simultaneous requests to the same address are still serialized: D first unless force_i.
- Reset:
  - Async assert clears resp_sel, resp_oob, stall_cnt and addr_hold immediately.
  - All outputs go 0 except rom_addr, which goes 0 when no req is present.
  - A response in flight at reset is dropped, never delivered.
  - First grant possible in the first cycle after deassertion.
- No combinational path from rom_data to any grant.

Test Plan:
- Idle, then i_req with i_addr=0x00 for 1 cycle -> i_gnt=1 same cycle; next cycle i_rvalid=1, i_rdata=0x37070010, i_err=0, d_rvalid=0.
- d_req with d_addr=0x3E, and i_req with i_addr=0x01 in the same cycle -> d_gnt=1, i_gnt=0; next cycle d_rdata=0x48454C4C and i_gnt=1; the cycle after, i_rdata=0x13070760.
- i_req and d_req held high continuously (MAX_STALL=4) -> D granted cycles 0-3, I cycle 4, D 5-8, I 9; stall_cnt reads 4 at cycles 4 and 9.
- d_req with d_addr=0x42 -> d_gnt=1; next cycle d_rvalid=1, d_err=1, d_rdata=0. Then d_addr=0x41 -> d_rdata=0x21000000, d_err=0.
- Alternating single-cycle grants I(0x37), D(0x40), I(0x05), no req -> responses 0x67800000 (I), 0x524C4421 (D), 0x01000000 (I) on consecutive cycles; rom_addr holds 0x05 in the idle cycle.
- Grant D at 0x3F, assert rst low mid-cycle before the next edge -> d_rvalid never asserts; after release, a new i_req at 0x02 returns 0xEF004000 after 1 cycle.
